// File: rtl/ex_mem_register.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ex_mem_register: EX/MEM pipeline register with dword stack split   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module ex_mem_register #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic            ex_sp_or_alu,
  input  logic [1:0]      ex_sp_op,
  input  logic [DW-1:0]   ex_reg_src,
  input  logic [DW-1:0]   ex_alu_result,
  input  logic            ex_dword,
  input  logic [2*DW-1:0] ex_dword_data,
  input  logic            ex_wb_en,
  input  logic [RW-1:0]   ex_rdst,
  input  logic            stall,
  input  logic            flush,
  output logic            ex_ready,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            SPOrALUres,
  output logic [1:0]      SPOpeartion,
  output logic [DW-1:0]   RegSrc,
  output logic [DW-1:0]   Data_result,
  output logic            mem_valid,
  output logic            mem_wb_en,
  output logic [RW-1:0]   mem_rdst,
  output logic            mem_word_sel
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WORD0 = 2'd1,
    WORD1 = 2'd2
  } state_t;

  localparam logic [1:0] SP_NONE = 2'b00;
  localparam logic [1:0] SP_PUSH = 2'b01;

  state_t        state_q, state_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic          sp_or_alu_q, sp_or_alu_d;
  logic [1:0]    sp_op_q, sp_op_d;
  logic [DW-1:0] reg_src_q, reg_src_d;
  logic [DW-1:0] data_result_q, data_result_d;
  logic          valid_q, valid_d;
  logic          wb_en_q, wb_en_d;
  logic [RW-1:0] rdst_q, rdst_d;
  logic          word_sel_q, word_sel_d;
  logic [DW-1:0] low_half_q, low_half_d;
  logic          flush_pending_q, flush_pending_d;
  logic [1:0]    sp_op_clean;

  // Reserved encodings and ALU-addressed accesses never move SP.
  assign sp_op_clean = (ex_sp_op == 2'b11 || ex_sp_or_alu) ? SP_NONE : ex_sp_op;

  always_comb begin
    state_d         = state_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    sp_or_alu_d     = sp_or_alu_q;
    sp_op_d         = sp_op_q;
    reg_src_d       = reg_src_q;
    data_result_d   = data_result_q;
    valid_d         = valid_q;
    wb_en_d         = wb_en_q;
    rdst_d          = rdst_q;
    word_sel_d      = word_sel_q;
    low_half_d      = low_half_q;
    flush_pending_d = flush_pending_q;

    if (!stall) begin
      if (state_q == WORD0) begin
        // Second half of a dword op; a flush here is deferred, not applied.
        state_d         = WORD1;
        word_sel_d      = 1'b1;
        reg_src_d       = (sp_op_q == SP_PUSH) ? low_half_q : '0;
        flush_pending_d = flush_pending_q | flush;
      end else if (flush || flush_pending_q || !ex_valid) begin
        state_d         = IDLE;
        mem_read_d      = 1'b0;
        mem_write_d     = 1'b0;
        sp_or_alu_d     = 1'b0;
        sp_op_d         = SP_NONE;
        reg_src_d       = '0;
        data_result_d   = '0;
        valid_d         = 1'b0;
        wb_en_d         = 1'b0;
        rdst_d          = '0;
        word_sel_d      = 1'b0;
        low_half_d      = '0;
        flush_pending_d = 1'b0;
      end else begin
        mem_read_d      = ex_mem_read & ~ex_mem_write;
        mem_write_d     = ex_mem_write;
        sp_or_alu_d     = ex_sp_or_alu;
        sp_op_d         = sp_op_clean;
        data_result_d   = ex_alu_result;
        valid_d         = 1'b1;
        wb_en_d         = ex_wb_en;
        rdst_d          = ex_rdst;
        flush_pending_d = 1'b0;
        if (ex_dword) begin
          state_d    = WORD0;
          word_sel_d = 1'b0;
          reg_src_d  = (sp_op_clean == SP_PUSH) ? ex_dword_data[2*DW-1:DW] : '0;
          low_half_d = ex_dword_data[DW-1:0];
        end else begin
          state_d    = IDLE;
          word_sel_d = 1'b1;
          reg_src_d  = ex_reg_src;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      sp_or_alu_q     <= 1'b0;
      sp_op_q         <= SP_NONE;
      reg_src_q       <= '0;
      data_result_q   <= '0;
      valid_q         <= 1'b0;
      wb_en_q         <= 1'b0;
      rdst_q          <= '0;
      word_sel_q      <= 1'b0;
      low_half_q      <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      sp_or_alu_q     <= sp_or_alu_d;
      sp_op_q         <= sp_op_d;
      reg_src_q       <= reg_src_d;
      data_result_q   <= data_result_d;
      valid_q         <= valid_d;
      wb_en_q         <= wb_en_d;
      rdst_q          <= rdst_d;
      word_sel_q      <= word_sel_d;
      low_half_q      <= low_half_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  // Side-effecting strobes are masked while stalled so no access repeats.
  assign ex_ready     = ~stall & (state_q != WORD0);
  assign MemRead      = mem_read_q & ~stall;
  assign MemWrite     = mem_write_q & ~stall;
  assign SPOpeartion  = stall ? SP_NONE : sp_op_q;
  assign SPOrALUres   = sp_or_alu_q;
  assign RegSrc       = reg_src_q;
  assign Data_result  = data_result_q;
  assign mem_valid    = valid_q;
  assign mem_wb_en    = wb_en_q;
  assign mem_rdst     = rdst_q;
  assign mem_word_sel = word_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_register.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ex_mem_register: scoreboard bench for ex_mem_register           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_ex_mem_register;

  typedef struct packed {
    logic        rst, stall, flush, v, mr, mw, sa;
    logic [1:0]  op;
    logic [15:0] rs, alu;
    logic        dw;
    logic [31:0] dd;
    logic        wb;
    logic [2:0]  rd;
  } stim_t;

  typedef struct packed {
    logic        v, mr, mw, sa;
    logic [1:0]  op;
    logic [15:0] rs, dr;
    logic        wb;
    logic [2:0]  rd;
    logic        ws;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, ex_valid, ex_mem_read, ex_mem_write, ex_sp_or_alu;
  logic [1:0]  ex_sp_op;
  logic [15:0] ex_reg_src, ex_alu_result;
  logic        ex_dword;
  logic [31:0] ex_dword_data;
  logic        ex_wb_en;
  logic [2:0]  ex_rdst;
  logic        stall, flush;
  logic        ex_ready, MemRead, MemWrite, SPOrALUres;
  logic [1:0]  SPOpeartion;
  logic [15:0] RegSrc, Data_result;
  logic        mem_valid, mem_wb_en;
  logic [2:0]  mem_rdst;
  logic        mem_word_sel;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  ex_mem_register #(.DW(16), .RW(3)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_sp_or_alu(ex_sp_or_alu), .ex_sp_op(ex_sp_op),
    .ex_reg_src(ex_reg_src), .ex_alu_result(ex_alu_result), .ex_dword(ex_dword),
    .ex_dword_data(ex_dword_data), .ex_wb_en(ex_wb_en), .ex_rdst(ex_rdst),
    .stall(stall), .flush(flush), .ex_ready(ex_ready), .MemRead(MemRead),
    .MemWrite(MemWrite), .SPOrALUres(SPOrALUres), .SPOpeartion(SPOpeartion),
    .RegSrc(RegSrc), .Data_result(Data_result), .mem_valid(mem_valid),
    .mem_wb_en(mem_wb_en), .mem_rdst(mem_rdst), .mem_word_sel(mem_word_sel)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cyc%0d %s: got %0h expected %0h", cyc, tag, act, exp);
    end
  endtask

  function automatic stim_t mk_st(input logic v, mr, mw, sa, input logic [1:0] op,
                                  input logic [15:0] rs, alu, input logic dw,
                                  input logic [31:0] dd, input logic wb, input logic [2:0] rd);
    stim_t s;
    s = '0;
    s.v = v; s.mr = mr; s.mw = mw; s.sa = sa; s.op = op; s.rs = rs; s.alu = alu;
    s.dw = dw; s.dd = dd; s.wb = wb; s.rd = rd;
    return s;
  endfunction

  function automatic exp_t mk_ex(input logic v, mr, mw, sa, input logic [1:0] op,
                                 input logic [15:0] rs, dr, input logic wb,
                                 input logic [2:0] rd, input logic ws);
    exp_t e;
    e.v = v; e.mr = mr; e.mw = mw; e.sa = sa; e.op = op; e.rs = rs; e.dr = dr;
    e.wb = wb; e.rd = rd; e.ws = ws;
    return e;
  endfunction

  // Drive one cycle of stimulus, queue what the next cycle must show,
  // then compare this cycle's outputs against the previously queued entry.
  task automatic step(input stim_t s, input exp_t nxt, input logic rdy);
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    rst = s.rst; stall = s.stall; flush = s.flush; ex_valid = s.v;
    ex_mem_read = s.mr; ex_mem_write = s.mw; ex_sp_or_alu = s.sa; ex_sp_op = s.op;
    ex_reg_src = s.rs; ex_alu_result = s.alu; ex_dword = s.dw; ex_dword_data = s.dd;
    ex_wb_en = s.wb; ex_rdst = s.rd;
    exp_q.push_back(nxt);
    @(negedge clk);
    e = exp_q.pop_front();
    check_eq("ex_ready",     32'(ex_ready),     32'(rdy));
    check_eq("mem_valid",    32'(mem_valid),    32'(e.v));
    check_eq("MemRead",      32'(MemRead),      32'(e.mr & ~s.stall));
    check_eq("MemWrite",     32'(MemWrite),     32'(e.mw & ~s.stall));
    check_eq("SPOrALUres",   32'(SPOrALUres),   32'(e.sa));
    check_eq("SPOpeartion",  32'(SPOpeartion),  32'(s.stall ? 2'b00 : e.op));
    check_eq("RegSrc",       32'(RegSrc),       32'(e.rs));
    check_eq("Data_result",  32'(Data_result),  32'(e.dr));
    check_eq("mem_wb_en",    32'(mem_wb_en),    32'(e.wb));
    check_eq("mem_rdst",     32'(mem_rdst),     32'(e.rd));
    check_eq("mem_word_sel", 32'(mem_word_sel), 32'(e.ws));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s, st_store, st_push16;
    exp_t  z, e_store, e_push16;
    z = '0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0;
    ex_mem_write = 1'b0; ex_sp_or_alu = 1'b0; ex_sp_op = 2'b00; ex_reg_src = '0;
    ex_alu_result = '0; ex_dword = 1'b0; ex_dword_data = '0; ex_wb_en = 1'b0; ex_rdst = '0;
    repeat (2) @(posedge clk);
    exp_q.push_back(z);

    // Single-word ALU-addressed store, then bubble
    step(mk_st(1,0,1,1,2'b00,16'd4,16'd2,0,32'h0,0,3'd0), mk_ex(1,0,1,1,2'b00,16'd4,16'd2,0,3'd0,1), 1);
    step(mk_st(0,0,0,0,2'b00,16'd0,16'd0,0,32'h0,0,3'd0), z, 1);
    // Load with write-back, then mid-stream reset
    step(mk_st(1,1,0,1,2'b00,16'd0,16'd7,0,32'h0,1,3'd3), mk_ex(1,1,0,1,2'b00,16'd0,16'd7,1,3'd3,1), 1);
    s = mk_st(1,0,1,1,2'b00,16'd9,16'd9,0,32'h0,1,3'd1); s.rst = 1'b1;
    step(s, z, 1);

    // Dword push split high then low; next EX op held until WORD1
    step(mk_st(1,0,1,0,2'b01,16'd0,16'h00FE,1,32'h1234_ABCD,0,3'd0),
         mk_ex(1,0,1,0,2'b01,16'h1234,16'h00FE,0,3'd0,0), 1);
    st_store = mk_st(1,0,1,1,2'b00,16'd9,16'd5,0,32'h0,0,3'd0);
    e_store  = mk_ex(1,0,1,1,2'b00,16'd9,16'd5,0,3'd0,1);
    step(st_store, mk_ex(1,0,1,0,2'b01,16'hABCD,16'h00FE,0,3'd0,1), 0);
    step(st_store, e_store, 1);

    // Dword pop: two consecutive reads, word_sel 0 then 1
    step(mk_st(1,1,0,0,2'b10,16'h7777,16'h0040,1,32'hFFFF_FFFF,1,3'd5),
         mk_ex(1,1,0,0,2'b10,16'd0,16'h0040,1,3'd5,0), 1);
    step(mk_st(0,0,0,0,2'b00,16'd0,16'd0,0,32'h0,0,3'd0), mk_ex(1,1,0,0,2'b10,16'd0,16'h0040,1,3'd5,1), 0);
    step(mk_st(0,0,0,0,2'b00,16'd0,16'd0,0,32'h0,0,3'd0), z, 1);

    // Single-word push of 16 stalled for three cycles
    st_push16 = mk_st(1,0,1,0,2'b01,16'd16,16'd0,0,32'h0,0,3'd0);
    e_push16  = mk_ex(1,0,1,0,2'b01,16'd16,16'd0,0,3'd0,1);
    step(st_push16, e_push16, 1);
    st_store = mk_st(1,0,1,1,2'b00,16'd3,16'd3,0,32'h0,0,3'd0);
    e_store  = mk_ex(1,0,1,1,2'b00,16'd3,16'd3,0,3'd0,1);
    s = st_store; s.stall = 1'b1;
    for (int i = 0; i < 3; i++) step(s, e_push16, 0);
    step(st_store, e_store, 1);

    // Flush of a valid instruction yields a bubble
    s = mk_st(1,1,0,1,2'b00,16'd0,16'd8,0,32'h0,1,3'd2); s.flush = 1'b1;
    step(s, z, 1);

    // Flush during WORD0: low half still issues, then a bubble
    step(mk_st(1,0,1,0,2'b01,16'd0,16'd0,1,32'hCAFE_0001,0,3'd0),
         mk_ex(1,0,1,0,2'b01,16'hCAFE,16'd0,0,3'd0,0), 1);
    s = mk_st(1,0,1,1,2'b00,16'd6,16'd6,0,32'h0,0,3'd0); s.flush = 1'b1;
    step(s, mk_ex(1,0,1,0,2'b01,16'h0001,16'd0,0,3'd0,1), 0);
    step(mk_st(1,0,1,1,2'b00,16'd6,16'd6,0,32'h0,0,3'd0), z, 1);

    // Illegal inputs: read+write, reserved SP op, ALU-addressed push
    step(mk_st(1,1,1,1,2'b00,16'h0022,16'h0011,0,32'h0,0,3'd0),
         mk_ex(1,0,1,1,2'b00,16'h0022,16'h0011,0,3'd0,1), 1);
    step(mk_st(1,0,0,0,2'b11,16'd0,16'h0033,0,32'h0,0,3'd0),
         mk_ex(1,0,0,0,2'b00,16'd0,16'h0033,0,3'd0,1), 1);
    step(mk_st(1,0,1,1,2'b01,16'd5,16'h0044,0,32'h0,0,3'd0),
         mk_ex(1,0,1,1,2'b00,16'd5,16'h0044,0,3'd0,1), 1);
    step(mk_st(0,0,0,0,2'b00,16'd0,16'd0,0,32'h0,0,3'd0), z, 1);
    step(mk_st(0,0,0,0,2'b00,16'd0,16'd0,0,32'h0,0,3'd0), z, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
